// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage: FSM encoding, reset PC and PC helpers.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StSkid
    } fetch_state_e;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory handshake, hazard/redirect controls and the IF/ID register.
interface fetch_if;
    import fetch_pkg::*;

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_inst;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_pc_plus4;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
        output imem_req, imem_addr, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_ready, imem_rdata,
        input  imem_req, imem_addr, if_id_valid, if_id_inst, if_id_pc, if_id_pc_plus4
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {inst, pc} holding register for a word that returns while decode is stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (clear_i || unload_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, multi-cycle imem request FSM, stale-response drain and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds delivered-word and bubble counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_bubbles_o,
`endif
    fetch_if.master     fetch_bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            outstanding_q, outstanding_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_inst_q, if_inst_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_pc4_q, if_pc4_d;

    logic            req, accept, stall, redirect;
    logic [XLEN-1:0] redirect_tgt;
    logic            skid_load, skid_unload, skid_clear, skid_valid;
    logic [XLEN-1:0] skid_inst, skid_pc;

    assign stall         = fetch_bus.stall;
    assign redirect      = fetch_bus.redirect_valid;
    assign redirect_tgt  = align_pc(fetch_bus.redirect_pc);
    assign accept        = req && fetch_bus.imem_ready;
    assign outstanding_d = req && !fetch_bus.imem_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (accept) begin
                    if (!redirect && stall) state_d = StSkid;
                end else if (req && redirect) begin
                    state_d = StDrain;
                end
            end
            StSkid:  if (redirect || !stall) state_d = StSkid == state_q ? StFetch : state_q;
            StDrain: if (accept) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // A request that went out unanswered must stay up even under stall.
    always_comb begin
        req = 1'b0;
        unique case (state_q)
            StFetch: req = !stall || outstanding_q;
            StDrain: req = 1'b1;
            default: req = 1'b0;
        endcase
    end

    assign fetch_bus.imem_req  = req;
    assign fetch_bus.imem_addr = pc_q;

    always_comb begin
        pc_d        = pc_q;
        pend_pc_d   = pend_pc_q;
        if_valid_d  = if_valid_q;
        if_inst_d   = if_inst_q;
        if_pc_d     = if_pc_q;
        if_pc4_d    = if_pc4_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (accept) begin
                    pc_d = pc_plus4(pc_q);
                    if (redirect) begin
                        pc_d = redirect_tgt;
                    end else if (stall) begin
                        skid_load = 1'b1;
                    end else begin
                        if_valid_d = 1'b1;
                        if_inst_d  = fetch_bus.imem_rdata;
                        if_pc_d    = pc_q;
                        if_pc4_d   = pc_plus4(pc_q);
                    end
                end else if (redirect) begin
                    // In-flight request keeps its address; the target waits in pend_pc.
                    if (req) pend_pc_d = redirect_tgt;
                    else     pc_d      = redirect_tgt;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    if_inst_d  = INST_NOP;
                end
            end
            StSkid: begin
                if (redirect) begin
                    skid_clear = 1'b1;
                    pc_d       = redirect_tgt;
                end else if (!stall) begin
                    skid_unload = 1'b1;
                    if_valid_d  = skid_valid;
                    if_inst_d   = skid_valid ? skid_inst : INST_NOP;
                    if_pc_d     = skid_valid ? skid_pc : if_pc_q;
                    if_pc4_d    = skid_valid ? pc_plus4(skid_pc) : if_pc4_q;
                end
            end
            StDrain: begin
                if (redirect) pend_pc_d = redirect_tgt;
                if (accept)   pc_d      = redirect ? redirect_tgt : pend_pc_q;
                if (!redirect && !stall) begin
                    if_valid_d = 1'b0;
                    if_inst_d  = INST_NOP;
                end
            end
            default: ;
        endcase

        if (redirect && state_q != StIdle) if_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= RESET_PC;
            pend_pc_q     <= RESET_PC;
            outstanding_q <= 1'b0;
            if_valid_q    <= 1'b0;
            if_inst_q     <= '0;
            if_pc_q       <= '0;
            if_pc4_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            outstanding_q <= outstanding_d;
            if_valid_q    <= if_valid_d;
            if_inst_q     <= if_inst_d;
            if_pc_q       <= if_pc_d;
            if_pc4_q      <= if_pc4_d;
        end
    end

    assign fetch_bus.if_id_valid    = if_valid_q;
    assign fetch_bus.if_id_inst     = if_inst_q;
    assign fetch_bus.if_id_pc       = if_pc_q;
    assign fetch_bus.if_id_pc_plus4 = if_pc4_q;

    fetch_skid_buffer u_skid (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .inst_i   (fetch_bus.imem_rdata),
        .pc_i     (pc_q),
        .valid_o  (skid_valid),
        .inst_o   (skid_inst),
        .pc_o     (skid_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_bubbles_q;
    logic        if_id_update;

    assign if_id_update = (state_q != StIdle) && !redirect && !stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else if (if_id_update) begin
            if (if_valid_d) perf_fetched_q <= perf_fetched_q + 32'd1;
            else            perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_bubbles_o = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences and a randomized
// run against a program-order model of the delivered instruction stream.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    fetch_unit dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched_o (perf_fetched),
        .perf_bubbles_o (perf_bubbles),
`endif
        .fetch_bus      (bus)
    );

    logic        s_req;
    logic [31:0] s_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // rdy: 0 = not ready, 1 = ready, 2 = zero-wait memory (ready follows req)
    task automatic step(input logic s, input logic r, input logic [31:0] rp, input int rdy);
        bus.stall = s;
        bus.redirect_valid = r;
        bus.redirect_pc = rp;
        #1;
        bus.imem_ready = (rdy == 2) ? bus.imem_req : (rdy == 1);
        bus.imem_rdata = inst_of(bus.imem_addr);
        #1;
        s_req = bus.imem_req;
        s_addr = bus.imem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string name, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
        chk({name, ".req"}, {31'd0, s_req}, {31'd0, req});
        chk({name, ".addr"}, s_addr, addr);
        chk({name, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, valid});
        if (valid) begin
            chk({name, ".pc"}, bus.if_id_pc, pc);
            chk({name, ".pc4"}, bus.if_id_pc_plus4, pc + 32'd4);
            chk({name, ".inst"}, bus.if_id_inst, inst_of(pc));
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic        s, r, rdy_v, req_v, busy, pend_prev;
        logic [31:0] rp, prev_addr, exp_pc, h_pc, h_inst, h_pc4;
        logic        h_valid;
        int          wait_n, delivered, bubbles;

        vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h4};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h8,         1'b1, 32'h4};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'h8};
        vecs[5]  = '{1'b0, 1'b1, 32'h40,        1'b1, 32'hC,         1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h40,        1'b1, 32'h40};
        vecs[7]  = '{1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h44,        1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h4,         1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h4};

        // Asynchronous reset state, before any clock edge.
        #1 rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        #1;
        chk("rst.req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst.addr", bus.imem_addr, 32'h0);
        chk("rst.valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("rst.inst", bus.if_id_inst, 32'h0);
        chk("rst.pc", bus.if_id_pc, 32'h0);
        chk("rst.pc4", bus.if_id_pc_plus4, 32'h0);

        // Zero-wait memory vector table.
        do_reset();
        delivered = 0;
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].stall, vecs[i].redir, vecs[i].rpc, 2);
            expect_cyc($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                       vecs[i].exp_valid, vecs[i].exp_pc);
            if (i > 0 && !vecs[i].stall && !vecs[i].redir && vecs[i].exp_valid) delivered++;
        end
`ifdef FETCH_PERF_CNT_EN
        chk("vec.perf_fetched", perf_fetched, delivered);
        chk("vec.perf_bubbles", perf_bubbles, 32'd0);
`endif

        // Stall while the word @0x8 returns: skid, no req, then 0x8 and 0xC in order.
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 1); expect_cyc("skid.w0", 1, 32'h0, 1, 32'h0);
        step(0, 0, 0, 1); expect_cyc("skid.w4", 1, 32'h4, 1, 32'h4);
        step(0, 0, 0, 0); expect_cyc("skid.wait", 1, 32'h8, 0, 32'h0);
        step(1, 0, 0, 1); expect_cyc("skid.acc", 1, 32'h8, 0, 32'h0);
        step(1, 0, 0, 1); expect_cyc("skid.hold1", 0, 32'hC, 0, 32'h0);
        step(1, 0, 0, 1); expect_cyc("skid.hold2", 0, 32'hC, 0, 32'h0);
        step(0, 0, 0, 0); expect_cyc("skid.out", 0, 32'hC, 1, 32'h8);
        step(0, 0, 0, 1); expect_cyc("skid.next", 1, 32'hC, 1, 32'hC);

        // Redirect and stall together while the skid is full: buffered word dropped.
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 1, 32'h40, 0); expect_cyc("skidredir.flush", 0, 32'hC, 0, 32'h0);
        step(0, 0, 0, 1); expect_cyc("skidredir.w40", 1, 32'h40, 1, 32'h40);
        step(0, 0, 0, 1); expect_cyc("skidredir.w44", 1, 32'h44, 1, 32'h44);

        // 3-cycle memory, redirect to 0x100 while 0x10 is outstanding.
        do_reset();
        step(0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1);
        chk("drain.pre_pc", bus.if_id_pc, 32'hC);
        step(0, 0, 0, 0);          expect_cyc("drain.a", 1, 32'h10, 0, 32'h0);
        step(0, 1, 32'h100, 0);    expect_cyc("drain.b", 1, 32'h10, 0, 32'h0);
        step(0, 0, 0, 0);          expect_cyc("drain.c", 1, 32'h10, 0, 32'h0);
        step(0, 0, 0, 1);          expect_cyc("drain.d", 1, 32'h10, 0, 32'h0);
        step(0, 0, 0, 1);          expect_cyc("drain.e", 1, 32'h100, 1, 32'h100);

        // Reset pulsed mid-DRAIN; stale ready afterwards must be ignored.
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 1, 32'h200, 0);
        #3 rst_n = 1'b0;
        bus.imem_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        #1;
        chk("midrst.req", {31'd0, bus.imem_req}, 32'd0);
        chk("midrst.addr", bus.imem_addr, 32'h0);
        chk("midrst.valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("midrst.pc", bus.if_id_pc, 32'h0);
        chk("midrst.inst", bus.if_id_inst, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("midrst.perf_fetched", perf_fetched, 32'd0);
        chk("midrst.perf_bubbles", perf_bubbles, 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 1); expect_cyc("midrst.stale", 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 1); expect_cyc("midrst.first", 1, 32'h0, 1, 32'h0);

        // Randomized run: delivered words must follow program order, redirects restart it.
        do_reset();
        busy = 1'b0; wait_n = 0; pend_prev = 1'b0; prev_addr = '0;
        exp_pc = 32'h0; delivered = 0; bubbles = 0;
        h_valid = 1'b0; h_pc = '0; h_inst = '0; h_pc4 = '0;
        for (int c = 0; c < 3000; c++) begin
            s = (c > 0) && ($urandom_range(3) == 0);
            r = (c > 0) && ($urandom_range(9) == 0);
            rp = ($urandom_range(5) == 0) ? 32'hFFFF_FFF0 | $urandom_range(15)
                                           : $urandom_range(32'h3FF);
            bus.stall = s;
            bus.redirect_valid = r;
            bus.redirect_pc = rp;
            #1;
            req_v = bus.imem_req;
            if (req_v && !busy) begin
                busy = 1'b1;
                wait_n = $urandom_range(3);
            end
            rdy_v = req_v ? (wait_n == 0) : ($urandom_range(1) == 1);
            bus.imem_ready = rdy_v;
            bus.imem_rdata = inst_of(bus.imem_addr);
            #1;
            if (pend_prev) begin
                chk("rnd.hold_req", {31'd0, bus.imem_req}, 32'd1);
                chk("rnd.hold_addr", bus.imem_addr, prev_addr);
            end
            pend_prev = req_v && !rdy_v;
            prev_addr = bus.imem_addr;
            @(posedge clk);
            #1;
            if (busy) begin
                if (req_v && rdy_v) busy = 1'b0;
                else wait_n--;
            end
            if (r) begin
                chk("rnd.redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
                exp_pc = rp & 32'hFFFF_FFFC;
            end else if (s) begin
                chk("rnd.stall_valid", {31'd0, bus.if_id_valid}, {31'd0, h_valid});
                chk("rnd.stall_pc", bus.if_id_pc, h_pc);
                chk("rnd.stall_inst", bus.if_id_inst, h_inst);
                chk("rnd.stall_pc4", bus.if_id_pc_plus4, h_pc4);
            end else if (bus.if_id_valid) begin
                chk("rnd.pc", bus.if_id_pc, exp_pc);
                chk("rnd.inst", bus.if_id_inst, inst_of(exp_pc));
                chk("rnd.pc4", bus.if_id_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
            end
            if (c > 0 && !s && !r) begin
                if (bus.if_id_valid) delivered++;
                else bubbles++;
            end
            h_valid = bus.if_id_valid;
            h_pc = bus.if_id_pc;
            h_inst = bus.if_id_inst;
            h_pc4 = bus.if_id_pc_plus4;
        end
        checks++;
        if (delivered < 200) begin
            errors++;
            $display("FAIL rnd.progress actual=%0d expected>=200", delivered);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("rnd.perf_fetched", perf_fetched, delivered);
        chk("rnd.perf_bubbles", perf_bubbles, bubbles);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
